fv_mul_sched: RTL and testbench
===============================

# fv_mul_sched

Packet-level scheduler that shares one `multiplier_top` instance between two requesters, for example the c0 and c1 products of FV encryption. Each requester offers a paired coefficient stream p (QW bits) and u (UW bits) of N beats terminated by `last`. The block grants whole packets round-robin, forwards them to the multiplier, and routes each returning z packet back to the requester that issued it. Result routing uses an in-order tag FIFO.

## Interface
Parameters:
- `N`, 4: coefficients per packet.
- `QW`, 5: width of p and z data.
- `UW`, 1: width of u data.
- `TAGD`, 4: tag FIFO depth, i.e. the maximum number of packets in flight inside the multiplier (power of 2).

Ports. All streams are `axis_if` instances with fields vld, rdy, last, data.
- `clk`, in, 1: single clock; all logic on the rising edge.
- `s_rst_n`, in, 1: reset, synchronous and active-low.
- `p0`, `p1`, slave, QW: p streams from requesters 0 and 1.
- `u0`, `u1`, slave, UW: u streams from requesters 0 and 1.
- `z0`, `z1`, master, QW: result streams to requesters 0 and 1.
- `mp`, master, QW: p stream to the multiplier.
- `mu`, master, UW: u stream to the multiplier.
- `mz`, slave, QW: z stream from the multiplier.
- `busy`, out, 1: high when the state is GRANT.
- `err`, out, 1: sticky packet-length/alignment error (see Configuration).

## Operation
- Request from requester i: `pi.vld & ui.vld`.
- Forward path state machine, states IDLE and GRANT(owner):
  - IDLE to GRANT when any request is present and the tag FIFO is not full.
  - Round-robin: the requester granted most recently has lowest priority. The pointer resets to favour requester 0.
  - On grant: the owner register is loaded and its id is pushed into the tag FIFO in the same edge.
  - GRANT to IDLE on the edge where the beat carrying `p_sel.last` transfers.
- In GRANT, data path (combinational, no register stage):
  - `mp.vld = mu.vld = p_sel.vld & u_sel.vld`.
  - `mp.data/last` and `mu.data/last` come from the owner's streams.
  - `p_sel.rdy = mp.rdy & mu.rdy & u_sel.vld`.
  - `u_sel.rdy = mp.rdy & mu.rdy & p_sel.vld`.
  - A beat transfers only when all four signals are high, so p and u never slip relative to each other.
- Non-owner rdy is 0. In IDLE all forward vld/rdy are 0.
- Return path, active when the tag FIFO is non-empty, with head tag h:
  - `zh.vld = mz.vld`, `zh.data/last = mz.data/last`, `mz.rdy = zh.rdy`.
  - The other z port has vld = 0.
  - Pop on the transfer of the `mz.last` beat.
- Return path with the tag FIFO empty: `mz.rdy = 0`, z0.vld = z1.vld = 0.
- The multiplier preserves packet order, so the FIFO head always names the owner of the next result.
- A push and a pop in the same cycle are both honoured; the count is unchanged.
- A full FIFO blocks new grants only; a packet already in GRANT completes.

## Timing
- Reset: state IDLE, round-robin pointer at requester 0, FIFO empty, `busy = 0`, `err = 0`. All vld/rdy outputs are 0 on the cycle after the reset edge.
- Reset asserted mid-packet clears everything at that edge. The partial packet is abandoned with no flush, and the requester resends.
- Grant latency: a request seen in IDLE at edge k gives GRANT from edge k; the first beat can transfer in cycle k+1.
- Gap between packets: exactly one IDLE cycle after each last beat. Peak throughput is N beats per N+1 cycles.
- Forward and return pass-through add zero cycles of latency. The end-to-end latency equals the multiplier latency plus 1 grant cycle.
- Backpressure on `mp`/`mu` or on the owner's `zh` stalls the affected path without losing or duplicating a beat.

## Configuration
- `FV_SCHED_LEN_CHECK_EN` defined:
  - A beat counter (clog2(N)+1 bits) counts transfers in GRANT.
  - `err` is set if `p_sel.last` arrives on a beat other than N, or if `u_sel.last != p_sel.last` on any transferred beat.
  - `err` is cleared only by reset.
  - The packet still ends on `p_sel.last`.
- Undefined: the counter is absent and `err` is tied to 0.

## Test plan
- Single requester: p0 = 1,2,3,4 with u0 = 1, multiplier modelled as echo -> mp carries 1,2,3,4 with last on beat 4; z0 returns 1,2,3,4; z1.vld stays 0.
- Simultaneous requests after reset: both stream 4 beats, requester 0 with p = 5..8 and requester 1 with p = 24..27 -> grant order 0, 1, 0, 1; each z port receives only its own data.
- Tag full: `TAGD` = 4, mz.vld held 0, five packets offered -> four granted, fifth waits (busy = 0) until one result packet drains, then is granted the next cycle.
- Backpressure: mp.rdy = 0 for 3 cycles at beat 2 of p = 28..31 -> p0.rdy = 0 during the stall; mp sees exactly 28,29,30,31 once each.
- Reset mid-packet after beat 2, then a fresh packet p = 9..12 -> the fresh packet passes intact and no stale tag misroutes its result.
- With `FV_SCHED_LEN_CHECK_EN` defined: p0.last on beat 3 -> `err` = 1 from the next cycle and stays 1 through subsequent good packets until reset.

Source files
------------

// File: rtl/fv_mul_sched.sv
// fv_mul_sched: shares one multiplier between two requesters at packet
// granularity. Whole packets are granted round-robin and forwarded to the
// multiplier. The owner of each granted packet is recorded in an in-order
// tag FIFO, which steers each returning z packet back to its requester.
//
// Optional feature: define FV_SCHED_LEN_CHECK_EN to enable the beat counter
// and the sticky packet-length/alignment error flag. When it is undefined,
// err is tied low.
//
// TAGD must be a power of two and at least 2.
module fv_mul_sched #(
    parameter int unsigned N    = 4,
    parameter int unsigned QW   = 5,
    parameter int unsigned UW   = 1,
    parameter int unsigned TAGD = 4
) (
    input  logic          clk,
    input  logic          s_rst_n,
    // requester 0 p/u streams
    input  logic          p0_vld,
    output logic          p0_rdy,
    input  logic          p0_last,
    input  logic [QW-1:0] p0_data,
    input  logic          u0_vld,
    output logic          u0_rdy,
    input  logic          u0_last,
    input  logic [UW-1:0] u0_data,
    // requester 1 p/u streams
    input  logic          p1_vld,
    output logic          p1_rdy,
    input  logic          p1_last,
    input  logic [QW-1:0] p1_data,
    input  logic          u1_vld,
    output logic          u1_rdy,
    input  logic          u1_last,
    input  logic [UW-1:0] u1_data,
    // result streams back to the requesters
    output logic          z0_vld,
    input  logic          z0_rdy,
    output logic          z0_last,
    output logic [QW-1:0] z0_data,
    output logic          z1_vld,
    input  logic          z1_rdy,
    output logic          z1_last,
    output logic [QW-1:0] z1_data,
    // multiplier side
    output logic          mp_vld,
    input  logic          mp_rdy,
    output logic          mp_last,
    output logic [QW-1:0] mp_data,
    output logic          mu_vld,
    input  logic          mu_rdy,
    output logic          mu_last,
    output logic [UW-1:0] mu_data,
    input  logic          mz_vld,
    output logic          mz_rdy,
    input  logic          mz_last,
    input  logic [QW-1:0] mz_data,
    // status
    output logic          busy,
    output logic          err
);

    localparam int unsigned PtrW = $clog2(TAGD);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StGrant = 1'b1;

    logic [0:0]    state_q, state_d;
    logic          owner_q, owner_d;
    // Requester that wins a tie; the one granted last loses.
    logic          prio_q, prio_d;

    logic          tag_mem_q [TAGD];
    logic [PtrW:0] wr_ptr_q, rd_ptr_q;
    logic          fifo_full, fifo_empty;
    logic          head_tag;
    logic          push, pop;

    logic          req0, req1;
    logic          grant_en, grant_id;

    logic          p_sel_vld, p_sel_last, u_sel_vld, u_sel_last;
    logic [QW-1:0] p_sel_data;
    logic [UW-1:0] u_sel_data;
    logic          in_grant;
    logic          fwd_vld, fwd_fire, pkt_end;

    assign req0 = p0_vld & u0_vld;
    assign req1 = p1_vld & u1_vld;

    // Full: pointers differ only in the wrap bit.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                        (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign head_tag   = tag_mem_q[rd_ptr_q[PtrW-1:0]];

    assign in_grant = (state_q == StGrant);
    assign busy     = in_grant;

    // Arbitration: decide whether to grant from IDLE and which requester wins.
    always_comb begin
        grant_en = (state_q == StIdle) && (req0 || req1) && !fifo_full;
        if (req0 && req1) begin
            grant_id = prio_q;
        end else begin
            grant_id = req1;
        end
    end

    assign push = grant_en;

    // Select the owner's p and u streams.
    always_comb begin
        if (owner_q) begin
            p_sel_vld  = p1_vld;
            p_sel_last = p1_last;
            p_sel_data = p1_data;
            u_sel_vld  = u1_vld;
            u_sel_last = u1_last;
            u_sel_data = u1_data;
        end else begin
            p_sel_vld  = p0_vld;
            p_sel_last = p0_last;
            p_sel_data = p0_data;
            u_sel_vld  = u0_vld;
            u_sel_last = u0_last;
            u_sel_data = u0_data;
        end
    end

    // p and u advance only together, so they can never slip against each other.
    assign fwd_vld  = in_grant & p_sel_vld & u_sel_vld;
    assign fwd_fire = fwd_vld & mp_rdy & mu_rdy;
    assign pkt_end  = fwd_fire & p_sel_last;

    assign mp_vld  = fwd_vld;
    assign mp_data = p_sel_data;
    assign mp_last = p_sel_last;
    assign mu_vld  = fwd_vld;
    assign mu_data = u_sel_data;
    assign mu_last = u_sel_last;

    // Forward ready: only the owner sees ready, and only while in GRANT.
    always_comb begin
        p0_rdy = 1'b0;
        u0_rdy = 1'b0;
        p1_rdy = 1'b0;
        u1_rdy = 1'b0;
        if (in_grant) begin
            if (owner_q) begin
                p1_rdy = mp_rdy & mu_rdy & u1_vld;
                u1_rdy = mp_rdy & mu_rdy & p1_vld;
            end else begin
                p0_rdy = mp_rdy & mu_rdy & u0_vld;
                u0_rdy = mp_rdy & mu_rdy & p0_vld;
            end
        end
    end

    // Return path: the FIFO head names the owner of the packet coming back.
    always_comb begin
        z0_vld = 1'b0;
        z1_vld = 1'b0;
        mz_rdy = 1'b0;
        if (!fifo_empty) begin
            if (head_tag) begin
                z1_vld = mz_vld;
                mz_rdy = z1_rdy;
            end else begin
                z0_vld = mz_vld;
                mz_rdy = z0_rdy;
            end
        end
    end

    assign z0_data = mz_data;
    assign z0_last = mz_last;
    assign z1_data = mz_data;
    assign z1_last = mz_last;

    assign pop = mz_vld & mz_rdy & mz_last;

    // Next-state logic for the grant FSM, owner and round-robin pointer.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        case (state_q)
            StIdle: begin
                if (grant_en) begin
                    state_d = StGrant;
                    owner_d = grant_id;
                    prio_d  = ~grant_id;
                end
            end
            StGrant: begin
                if (pkt_end) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM, owner, pointer and FIFO pointer registers.
    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            state_q  <= StIdle;
            owner_q  <= 1'b0;
            prio_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Tag storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem_q[wr_ptr_q[PtrW-1:0]] <= grant_id;
        end
    end

`ifdef FV_SCHED_LEN_CHECK_EN
    localparam int unsigned CntW = $clog2(N) + 1;

    logic [CntW-1:0] beat_cnt_q, beat_cnt_d;
    logic [CntW-1:0] beat_num;
    logic            err_q, err_d;

    // Count transferred beats and flag a short/long packet or a u/p last skew.
    always_comb begin
        beat_num   = beat_cnt_q + 1'b1;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        if (fwd_fire) begin
            if (p_sel_last) begin
                beat_cnt_d = '0;
                if (beat_num != CntW'(N)) begin
                    err_d = 1'b1;
                end
            end else if (beat_cnt_q != '1) begin
                beat_cnt_d = beat_num;
            end
            if (u_sel_last != p_sel_last) begin
                err_d = 1'b1;
            end
        end
    end

    // Beat counter and sticky error flag; only reset clears err.
    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fv_mul_sched.sv
// Directed bench for fv_mul_sched with an echo multiplier model.
module tb_fv_mul_sched;

    localparam int N    = 4;
    localparam int QW   = 5;
    localparam int UW   = 1;
    localparam int TAGD = 4;
`ifdef FV_SCHED_LEN_CHECK_EN
    localparam int LenChk = 1;
`else
    localparam int LenChk = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          s_rst_n = 1'b0;
    logic          p0_vld = 0, p0_rdy, p0_last = 0;
    logic [QW-1:0] p0_data = '0;
    logic          u0_vld = 0, u0_rdy, u0_last = 0;
    logic [UW-1:0] u0_data = '0;
    logic          p1_vld = 0, p1_rdy, p1_last = 0;
    logic [QW-1:0] p1_data = '0;
    logic          u1_vld = 0, u1_rdy, u1_last = 0;
    logic [UW-1:0] u1_data = '0;
    logic          z0_vld, z0_rdy = 1, z0_last;
    logic [QW-1:0] z0_data;
    logic          z1_vld, z1_rdy = 1, z1_last;
    logic [QW-1:0] z1_data;
    logic          mp_vld, mp_rdy = 1, mp_last;
    logic [QW-1:0] mp_data;
    logic          mu_vld, mu_rdy = 1, mu_last;
    logic [UW-1:0] mu_data;
    logic          mz_vld = 0, mz_rdy, mz_last = 0;
    logic [QW-1:0] mz_data = '0;
    logic          busy, err;

    fv_mul_sched #(.N(N), .QW(QW), .UW(UW), .TAGD(TAGD)) dut (
        .clk(clk), .s_rst_n(s_rst_n),
        .p0_vld(p0_vld), .p0_rdy(p0_rdy), .p0_last(p0_last), .p0_data(p0_data),
        .u0_vld(u0_vld), .u0_rdy(u0_rdy), .u0_last(u0_last), .u0_data(u0_data),
        .p1_vld(p1_vld), .p1_rdy(p1_rdy), .p1_last(p1_last), .p1_data(p1_data),
        .u1_vld(u1_vld), .u1_rdy(u1_rdy), .u1_last(u1_last), .u1_data(u1_data),
        .z0_vld(z0_vld), .z0_rdy(z0_rdy), .z0_last(z0_last), .z0_data(z0_data),
        .z1_vld(z1_vld), .z1_rdy(z1_rdy), .z1_last(z1_last), .z1_data(z1_data),
        .mp_vld(mp_vld), .mp_rdy(mp_rdy), .mp_last(mp_last), .mp_data(mp_data),
        .mu_vld(mu_vld), .mu_rdy(mu_rdy), .mu_last(mu_last), .mu_data(mu_data),
        .mz_vld(mz_vld), .mz_rdy(mz_rdy), .mz_last(mz_last), .mz_data(mz_data),
        .busy(busy), .err(err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Logs filled by the monitor; echo multiplier queue.
    int mp_log[$];
    int mp_cyc[$];
    int mp_last_idx[$];
    int z0_log[$];
    int z1_log[$];
    int z0_last_cyc[$];
    int grant_cyc[$];
    int stall_cnt = 0;
    bit busy_d = 0;
    int mq_data[$];
    bit mq_last[$];
    bit mz_en = 1;
    bit mz_fire_pend = 0;

    // Monitor: inputs change only at posedge+1, so negedge handshakes transfer
    // at the following posedge.
    always @(negedge clk) begin
        if (s_rst_n) begin
            if (mp_vld && mp_rdy && mu_vld && mu_rdy) begin
                mp_log.push_back(int'(mp_data));
                mp_cyc.push_back(cyc);
                if (mp_last) mp_last_idx.push_back(mp_log.size());
                mq_data.push_back(int'(mp_data));
                mq_last.push_back(mp_last);
            end
            if (mp_vld && !mp_rdy) stall_cnt++;
            if (z0_vld && z0_rdy) begin
                z0_log.push_back(int'(z0_data));
                if (z0_last) z0_last_cyc.push_back(cyc);
            end
            if (z1_vld && z1_rdy) z1_log.push_back(int'(z1_data));
            mz_fire_pend = mz_vld && mz_rdy;
            if (busy && !busy_d) grant_cyc.push_back(cyc);
            busy_d = busy;
        end else begin
            busy_d       = 1'b0;
            mz_fire_pend = 1'b0;
        end
    end

    // Echo multiplier: returns forwarded beats in order on mz.
    always @(posedge clk) begin
        #1;
        if (!s_rst_n) begin
            mq_data.delete();
            mq_last.delete();
        end else if (mz_fire_pend && mq_data.size() > 0) begin
            void'(mq_data.pop_front());
            void'(mq_last.pop_front());
        end
        mz_fire_pend = 1'b0;
        if (mz_en && mq_data.size() > 0) begin
            mz_vld  = 1'b1;
            mz_data = QW'(mq_data[0]);
            mz_last = mq_last[0];
        end else begin
            mz_vld  = 1'b0;
            mz_data = '0;
            mz_last = 1'b0;
        end
    end

    task automatic clear_logs();
        mp_log.delete();
        mp_cyc.delete();
        mp_last_idx.delete();
        z0_log.delete();
        z1_log.delete();
        z0_last_cyc.delete();
        grant_cyc.delete();
        stall_cnt = 0;
    endtask

    task automatic do_reset();
        p0_vld = 0; u0_vld = 0; p0_last = 0; u0_last = 0;
        p1_vld = 0; u1_vld = 0; p1_last = 0; u1_last = 0;
        s_rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 s_rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_logs();
    endtask

    // Send beats 1..nbeats of a packet starting at value 'first', last on beat last_at.
    task automatic send_pkt(input int id, input int first, input int nbeats, input int last_at);
        logic [QW-1:0] d;
        logic          l;
        int            w;
        bit            fired;
        for (int b = 1; b <= nbeats; b++) begin
            d = QW'(first + b - 1);
            l = (b == last_at);
            if (id == 0) begin
                p0_vld = 1; p0_data = d; p0_last = l;
                u0_vld = 1; u0_data = UW'(1); u0_last = l;
            end else begin
                p1_vld = 1; p1_data = d; p1_last = l;
                u1_vld = 1; u1_data = UW'(1); u1_last = l;
            end
            w = 0;
            fired = 0;
            while (!fired && w < 200) begin
                @(negedge clk);
                fired = (id == 0) ? (p0_vld && p0_rdy) : (p1_vld && p1_rdy);
                @(posedge clk);
                #1;
                w++;
            end
            check_eq("send_beat_accepted", int'(fired), 1);
        end
        if (id == 0) begin
            p0_vld = 0; u0_vld = 0; p0_last = 0; u0_last = 0;
        end else begin
            p1_vld = 0; u1_vld = 0; p1_last = 0; u1_last = 0;
        end
    endtask

    task automatic wait_z(input int which, input int n, input string tag);
        int w = 0;
        while (((which == 0) ? z0_log.size() : z1_log.size()) < n && w < 400) begin
            @(negedge clk);
            w++;
        end
        check_eq(tag, (which == 0) ? z0_log.size() : z1_log.size(), n);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with a request pending: nothing may be granted.
        s_rst_n = 1'b0;
        p0_vld = 1; u0_vld = 1; p0_data = 5'd3;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_err", int'(err), 0);
        check_eq("rst_p0_rdy", int'(p0_rdy), 0);
        check_eq("rst_mp_vld", int'(mp_vld), 0);
        check_eq("rst_z0_vld", int'(z0_vld), 0);
        check_eq("rst_z1_vld", int'(z1_vld), 0);
        check_eq("rst_mz_rdy", int'(mz_rdy), 0);
        do_reset();

        // Single requester, echo multiplier.
        send_pkt(0, 1, 4, 4);
        wait_z(0, 4, "single_z0_count");
        check_eq("single_mp_count", mp_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check_eq("single_mp_data", (i < mp_log.size()) ? mp_log[i] : -1, i + 1);
            check_eq("single_z0_data", (i < z0_log.size()) ? z0_log[i] : -1, i + 1);
        end
        check_eq("single_last_count", mp_last_idx.size(), 1);
        check_eq("single_last_beat", (mp_last_idx.size() > 0) ? mp_last_idx[0] : -1, 4);
        check_eq("single_z1_quiet", z1_log.size(), 0);

        // Simultaneous requests from reset: grant order 0,1,0,1 at N per N+1.
        do_reset();
        begin
            int c0;
            int exp_mp[16];
            c0 = cyc;
            fork
                begin send_pkt(0, 5, 4, 4); send_pkt(0, 5, 4, 4); end
                begin send_pkt(1, 24, 4, 4); send_pkt(1, 24, 4, 4); end
            join
            wait_z(1, 8, "rr_z1_count");
            wait_z(0, 8, "rr_z0_count");
            for (int i = 0; i < 16; i++) exp_mp[i] = ((i / 4) % 2 == 0) ? 5 + i % 4 : 24 + i % 4;
            check_eq("rr_mp_count", mp_log.size(), 16);
            for (int i = 0; i < 16; i++)
                check_eq("rr_mp_order", (i < mp_log.size()) ? mp_log[i] : -1, exp_mp[i]);
            for (int i = 0; i < 8; i++) begin
                check_eq("rr_z0_data", (i < z0_log.size()) ? z0_log[i] : -1, 5 + i % 4);
                check_eq("rr_z1_data", (i < z1_log.size()) ? z1_log[i] : -1, 24 + i % 4);
            end
            check_eq("rr_throughput", (mp_cyc.size() == 16) ? mp_cyc[15] - c0 : -1, 19);
        end

        // Tag FIFO full: fifth packet waits until the first result drains.
        do_reset();
        mz_en = 0;
        fork
            begin
                for (int j = 0; j < 5; j++) send_pkt(0, 4 * j + 1, 4, 4);
            end
            begin
                int w = 0;
                while (mp_log.size() < 16 && w < 200) begin @(negedge clk); w++; end
                check_eq("full_four_granted", mp_log.size(), 16);
                repeat (5) @(negedge clk);
                check_eq("full_busy_low", int'(busy), 0);
                check_eq("full_p0_rdy", int'(p0_rdy), 0);
                check_eq("full_fifth_held", mp_log.size(), 16);
                @(posedge clk); #1;
                mz_en = 1;
            end
        join
        wait_z(0, 20, "full_z0_count");
        for (int i = 0; i < 20; i++)
            check_eq("full_z0_data", (i < z0_log.size()) ? z0_log[i] : -1, i + 1);
        check_eq("full_regrant_latency",
                 (grant_cyc.size() == 5 && z0_last_cyc.size() > 0) ?
                 grant_cyc[4] - z0_last_cyc[0] : -1, 2);

        // Backpressure on mp for 3 cycles at beat 2.
        do_reset();
        fork
            send_pkt(0, 28, 4, 4);
            begin
                int w = 0;
                while (mp_log.size() < 1 && w < 200) begin @(negedge clk); w++; end
                @(posedge clk); #1;
                mp_rdy = 0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check_eq("bp_p0_rdy_low", int'(p0_rdy), 0);
                end
                @(posedge clk); #1;
                mp_rdy = 1;
            end
        join
        wait_z(0, 4, "bp_z0_count");
        check_eq("bp_mp_count", mp_log.size(), 4);
        for (int i = 0; i < 4; i++)
            check_eq("bp_mp_data", (i < mp_log.size()) ? mp_log[i] : -1, 28 + i);
        check_eq("bp_stall_cycles", stall_cnt, 3);

        // Reset mid-packet, then a fresh packet from requester 1.
        do_reset();
        send_pkt(0, 13, 2, 4);
        do_reset();
        check_eq("midrst_busy", int'(busy), 0);
        send_pkt(1, 9, 4, 4);
        wait_z(1, 4, "midrst_z1_count");
        for (int i = 0; i < 4; i++)
            check_eq("midrst_z1_data", (i < z1_log.size()) ? z1_log[i] : -1, 9 + i);
        check_eq("midrst_z0_quiet", z0_log.size(), 0);
        check_eq("midrst_mp_count", mp_log.size(), 4);

        // Short packet: err is sticky when the length check is built in.
        do_reset();
        check_eq("len_err_clear", int'(err), 0);
        send_pkt(0, 1, 3, 3);
        check_eq("len_err_short", int'(err), LenChk);
        send_pkt(0, 5, 4, 4);
        wait_z(0, 7, "len_z0_count");
        check_eq("len_err_sticky", int'(err), LenChk);
        check_eq("len_busy_idle", int'(busy), 0);
        do_reset();
        check_eq("len_err_after_rst", int'(err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
